// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the immediate-decode stage.
//   fmt_e     3-bit immediate format tag driven on out_fmt
//   OPC_*     RV base opcodes (inst[6:0]) recognised by imm_extract
package imm_pkg;

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtSh   = 3'd2,
        FmtS    = 3'd3,
        FmtB    = 3'd4,
        FmtU    = 3'd5,
        FmtJ    = 3'd6,
        FmtZ    = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate generator.
//   inst  in   32    instruction word
//   imm   out  XLEN  sign/zero-extended immediate (0 when fmt is FmtNone)
//   fmt   out  3     immediate format tag
// Optional: define IMMGEN_ZICSR_EN to decode SYSTEM CSR ops (funct3 != 0) as FmtZ with the
// zero-extended CSR address; otherwise SYSTEM yields FmtNone.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    logic        sx;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Every immediate fits in 32 bits; widen to XLEN at the end, signed or not.
    always_comb begin
        imm32 = 32'h0;
        sx    = 1'b0;
        fmt   = FmtNone;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt   = FmtI;
                sx    = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // funct7 (arith/logical select) is not part of the shift amount.
                    fmt   = FmtSh;
                    imm32 = (XLEN == 64) ? {26'h0, inst[25:20]} : {27'h0, inst[24:20]};
                end else begin
                    fmt   = FmtI;
                    sx    = 1'b1;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    if (funct3 == 3'b000) begin
                        fmt   = FmtI;
                        sx    = 1'b1;
                        imm32 = {{20{inst[31]}}, inst[31:20]};
                    end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        fmt   = FmtSh;
                        imm32 = {27'h0, inst[24:20]};
                    end
                end
            end
            OPC_STORE: begin
                fmt   = FmtS;
                sx    = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FmtB;
                sx    = 1'b1;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_JAL: begin
                fmt   = FmtJ;
                sx    = 1'b1;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FmtU;
                sx    = 1'b1;
                imm32 = {inst[31:12], 12'h0};
            end
`ifdef IMMGEN_ZICSR_EN
            OPC_SYSTEM: begin
                if (funct3 != 3'b000) begin
                    fmt   = FmtZ;
                    imm32 = {20'h0, inst[31:20]};
                end
            end
`endif
            default: begin
                fmt   = FmtNone;
                imm32 = 32'h0;
            end
        endcase
    end

    assign imm = sx ? XLEN'($signed(imm32)) : XLEN'(imm32);

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate-decode stage with a 2-entry (output + skid) buffer.
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous kill of the output and skid entries
//   in_valid/in_ready   upstream handshake; in_ready is registered (= !skid_valid)
//   in_inst/pc/tag      instruction word, its PC, opaque sideband tag
//   out_valid/out_ready downstream handshake
//   out_imm/fmt/target  decoded immediate, format tag, in_pc + imm (mod 2^XLEN)
//   out_tag             sideband tag of the beat
// Optional: IMMGEN_ZICSR_EN (see imm_extract) enables CSR-address decode.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output fmt_e             out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [XLEN-1:0]  target;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic [XLEN-1:0] ext_imm;
    fmt_e            ext_fmt;
    beat_t           in_beat;

    beat_t out_q, out_d, skid_q, skid_d;
    logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic  in_fire, out_fire;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .inst (in_inst),
        .imm  (ext_imm),
        .fmt  (ext_fmt)
    );

    always_comb begin
        in_beat.imm    = ext_imm;
        in_beat.fmt    = ext_fmt;
        in_beat.target = in_pc + ext_imm;
        in_beat.tag    = in_tag;
    end

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // Data registers only load on a transfer; flush clears valids but leaves payloads alone.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid full implies in_ready=0, so only the drain path is live.
            if (out_fire) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_fire) begin
            out_valid_d = in_fire;
            if (in_fire) begin
                out_d = in_beat;
            end
        end else if (in_fire) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_imm    = out_q.imm;
    assign out_fmt    = out_q.fmt;
    assign out_target = out_q.target;
    assign out_tag    = out_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [5:0]  in_tag;

    logic        in_ready, out_valid;
    logic [31:0] out_imm, out_target;
    fmt_e        out_fmt;
    logic [5:0]  out_tag;

    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64, out_target64;
    fmt_e        out_fmt64;
    logic [5:0]  out_tag64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_target (out_target),
        .out_tag    (out_tag)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(6)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_inst    (in_inst),
        .in_pc      ({32'h0, in_pc}),
        .in_tag     (in_tag),
        .out_valid  (out_valid64),
        .out_ready  (out_ready),
        .out_imm    (out_imm64),
        .out_fmt    (out_fmt64),
        .out_target (out_target64),
        .out_tag    (out_tag64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one beat, clock it in, and check the 32-bit stage output.
    task automatic beat32(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] e_imm, input fmt_e e_fmt, input logic [31:0] e_tgt);
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        in_tag   = in_tag + 6'd1;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_imm"}, 64'(out_imm), 64'(e_imm));
        chk({tag, "_fmt"}, 64'(out_fmt), 64'(e_fmt));
        chk({tag, "_tgt"}, 64'(out_target), 64'(e_tgt));
        chk({tag, "_tag"}, 64'(out_tag), 64'(in_tag));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        in_tag    = 6'd0;
        #12;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_imm", 64'(out_imm), 64'(0));
        chk("rst_fmt", 64'(out_fmt), 64'(FmtNone));
        chk("rst_tgt", 64'(out_target), 64'(0));
        chk("rst_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_valid_idle", 64'(out_valid), 64'(0));

        // Directed decode vectors, streamed back to back.
        beat32("addi", 32'hFFF00093, 32'h0, 32'hFFFFFFFF, FmtI, 32'hFFFFFFFF);
        chk("addi64_imm", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        beat32("beq", 32'hFE000EE3, 32'h100, 32'hFFFFFFFC, FmtB, 32'h000000FC);
        beat32("srai", 32'h4030D093, 32'h10, 32'h3, FmtSh, 32'h13);
        chk("srai64_imm", out_imm64, 64'h3);
        beat32("lui", 32'h800002B7, 32'h0, 32'h80000000, FmtU, 32'h80000000);
        chk("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
        chk("lui64_fmt", 64'(out_fmt64), 64'(FmtU));
        beat32("jal", 32'h008000EF, 32'h200, 32'h8, FmtJ, 32'h208);
        beat32("sw", 32'hFE112E23, 32'h40, 32'hFFFFFFFC, FmtS, 32'h3C);
        beat32("rtype", 32'h00000033, 32'h44, 32'h0, FmtNone, 32'h44);
        beat32("addiw32", 32'h0010009B, 32'h8, 32'h0, FmtNone, 32'h8);
        chk("addiw64_imm", out_imm64, 64'h1);
        chk("addiw64_fmt", 64'(out_fmt64), 64'(FmtI));
        beat32("sraiw32", 32'h4050D09B, 32'h0, 32'h0, FmtNone, 32'h0);
        chk("sraiw64_imm", out_imm64, 64'h5);
        chk("sraiw64_fmt", 64'(out_fmt64), 64'(FmtSh));
`ifdef IMMGEN_ZICSR_EN
        beat32("csrrw", 32'h30029073, 32'h1000, 32'h300, FmtZ, 32'h1300);
`else
        beat32("csrrw", 32'h30029073, 32'h1000, 32'h0, FmtNone, 32'h1000);
`endif

        // Back-pressure: three beats offered while stalled, two accepted.
        @(negedge clk);
        in_valid  = 1'b0;
        step();
        chk("bp_idle", 64'(out_valid), 64'(0));
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;
        in_pc     = 32'h0;
        in_tag    = 6'd0;
        step();
        chk("bp_t0", 64'(out_tag), 64'(0));
        @(negedge clk);
        in_tag = 6'd1;
        step();
        chk("bp_skid_full", 64'(in_ready), 64'(0));
        chk("bp_hold_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        in_tag = 6'd2;
        step();
        chk("bp_still_full", 64'(in_ready), 64'(0));
        chk("bp_stable_tag", 64'(out_tag), 64'(0));
        chk("bp_stable_imm", 64'(out_imm), 64'(32'hFFFFFFFF));
        chk("bp_stable_valid", 64'(out_valid), 64'(1));
        @(negedge clk);
        out_ready = 1'b1;
        step();
        chk("bp_drain1", 64'(out_tag), 64'(1));
        chk("bp_ready_again", 64'(in_ready), 64'(1));
        step();
        chk("bp_drain2", 64'(out_tag), 64'(2));
        chk("bp_drain2_valid", 64'(out_valid), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(out_valid), 64'(0));

        // Flush with skid full and a beat presented in the same cycle.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 6'd5;
        step();
        @(negedge clk);
        in_tag = 6'd6;
        step();
        chk("fl_pre_full", 64'(in_ready), 64'(0));
        @(negedge clk);
        flush  = 1'b1;
        in_tag = 6'd7;
        step();
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl_no_stale", 64'(out_valid), 64'(0));

        // Asynchronous reset while stalled with skid full.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 6'd9;
        step();
        @(negedge clk);
        in_tag = 6'd10;
        step();
        chk("ar_pre_full", 64'(in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(0));
        chk("ar_in_ready", 64'(in_ready), 64'(1));
        chk("ar_tag", 64'(out_tag), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
